mul: RTL and testbench

Sequential 8x8 unsigned shift-add multiplier; the inverse of the team's restoring divider (`div`), and it shares the divider's `start`/`complete` handshake. The datapath computes P = A * B as a full 16-bit product, one multiplier bit per clock. It sits beside `div` in the ALU and is launched by a rising edge on `start`. It flags the result with `complete`.

---
 rtl/mul.sv | 103 ++++++++++
 tb/tb_mul.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul.sv
`default_nettype none
// ============================================================================
// Module   : mul
// Purpose  : Sequential 8x8 unsigned shift-add multiplier with a start/complete
//            handshake. Define MUL_EARLY_EXIT_EN to end RUN once no multiplier
//            bits remain.
// Revision : 1.0 - initial release
// ============================================================================
module mul (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        start,
    output logic [15:0] P,
    output logic        complete,
    output logic        busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_start_q;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [7:0]  r_mplier;
    logic [2:0]  r_count;
    logic [15:0] r_p;

    logic        w_start_edge;
    logic        w_accept;
    logic        w_finish;
    logic [15:0] w_next_acc;

    assign w_start_edge = start & ~r_start_q;
    assign w_accept     = w_start_edge && (r_state != c_ST_RUN);
    assign w_next_acc   = r_acc + (r_mplier[0] ? r_mcand : 16'd0);

`ifdef MUL_EARLY_EXIT_EN
    // Stop as soon as the remaining multiplier bits are all zero.
    assign w_finish = (r_count == 3'd7) || (r_mplier[7:1] == 7'd0);
`else
    assign w_finish = (r_count == 3'd7);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_finish) w_state_next = c_ST_DONE;
            c_ST_DONE: if (w_accept) w_state_next = c_ST_RUN;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == c_ST_RUN);
        complete = (r_state == c_ST_DONE);
    end

    // start_q tracks start unconditionally so an edge seen during RUN is consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q <= 1'b0;
            r_acc     <= 16'd0;
            r_mcand   <= 16'd0;
            r_mplier  <= 8'd0;
            r_count   <= 3'd0;
            r_p       <= 16'd0;
        end else begin
            r_start_q <= start;
            if (w_accept) begin
                r_mcand  <= {8'd0, A};
                r_mplier <= B;
                r_acc    <= 16'd0;
                r_count  <= 3'd0;
            end else if (r_state == c_ST_RUN) begin
                r_acc    <= w_next_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 3'd1;
                if (w_finish) begin
                    r_p <= w_next_acc;
                end
            end
        end
    end

    assign P = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul
// Purpose  : Directed self-checking bench for the mul shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul;

    logic        clock;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        start;
    logic [15:0] P;
    logic        complete;
    logic        busy;

    int n_checks;
    int n_fail;
    logic [15:0] last_p;

    mul dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .A        (A),
        .B        (B),
        .start    (start),
        .P        (P),
        .complete (complete),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic int lat_of(input logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int i = 0; i < 8; i++) if (b[i]) m = i;
        return 1 + m;
`else
        return 8;
`endif
    endfunction

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; A = 8'd0; B = 8'd0;
        tick; tick;
        n_checks++;
        if (P !== 16'd0 || complete !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: P=%h complete=%b busy=%b, required P=0000 complete=0 busy=0", P, complete, busy);
        end
        reset_n = 1'b1;
        last_p = 16'd0;
        tick;
    endtask

    // Launch one operation, scramble the operands afterwards, and check each cycle.
    task automatic test_multiply(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] exp);
        int lat;
        lat = lat_of(b);
        A = a; B = b; start = 1'b1;
        tick;
        start = 1'b0; A = ~a; B = ~b;
        n_checks++;
        if (busy !== 1'b1 || complete !== 1'b0 || P !== last_p) begin
            n_fail++;
            $display("FAIL %s_accept: busy=%b complete=%b P=%h, required busy=1 complete=0 P=%h", name, busy, complete, P, last_p);
        end
        for (int i = 1; i < lat; i++) begin
            tick;
            n_checks++;
            if (busy !== 1'b1 || complete !== 1'b0 || P !== last_p) begin
                n_fail++;
                $display("FAIL %s_run%0d: busy=%b complete=%b P=%h, required busy=1 complete=0 P=%h", name, i, busy, complete, P, last_p);
            end
        end
        tick;
        n_checks++;
        if (busy !== 1'b0 || complete !== 1'b1 || P !== exp) begin
            n_fail++;
            $display("FAIL %s_done: busy=%b complete=%b P=%h, required busy=0 complete=1 P=%h", name, busy, complete, P, exp);
        end
        last_p = exp;
        tick;
        n_checks++;
        if (complete !== 1'b1 || P !== exp) begin
            n_fail++;
            $display("FAIL %s_hold: complete=%b P=%h, required complete=1 P=%h", name, complete, P, exp);
        end
    endtask

    task automatic test_ignore_restart;
        int lat;
        lat = lat_of(8'd9);
        A = 8'd7; B = 8'd9; start = 1'b1;
        tick;                       // edge k
        start = 1'b0;
        tick; tick;                 // edges k+1, k+2
        A = 8'd1; B = 8'd1; start = 1'b1;
        tick;                       // edge k+3 sees a start edge while in RUN
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_busy: busy=%b, required 1", busy);
        end
        for (int i = 4; i < lat; i++) tick;
        tick;
        n_checks++;
        if (complete !== 1'b1 || busy !== 1'b0 || P !== 16'h003F) begin
            n_fail++;
            $display("FAIL restart_done: complete=%b busy=%b P=%h, required complete=1 busy=0 P=003f", complete, busy, P);
        end
        tick; tick;
        n_checks++;
        if (complete !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_no_replay: complete=%b busy=%b, required complete=1 busy=0", complete, busy);
        end
        last_p = 16'h003F;
    endtask

    task automatic test_reset_mid;
        A = 8'd200; B = 8'd100; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (P !== 16'd0 || complete !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: P=%h complete=%b busy=%b, required P=0000 complete=0 busy=0", P, complete, busy);
        end
        tick;
        reset_n = 1'b1;
        last_p = 16'd0;
        tick;
        test_multiply("after_reset", 8'd3, 8'd4, 16'h000C);
    endtask

    task automatic test_reset_start;
        reset_n = 1'b0; A = 8'd5; B = 8'd6; start = 1'b1;
        tick;
        reset_n = 1'b1;
        last_p = 16'd0;
        tick;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || complete !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_accept: busy=%b complete=%b, required busy=1 complete=0", busy, complete);
        end
        for (int i = 0; i < lat_of(8'd6); i++) tick;
        n_checks++;
        if (complete !== 1'b1 || P !== 16'd30) begin
            n_fail++;
            $display("FAIL reset_start_done: complete=%b P=%h, required complete=1 P=001e", complete, P);
        end
        last_p = 16'd30;
    endtask

    task automatic test_hold_start;
        int rises;
        logic prev;
        rises = 0;
        prev = complete;
        A = 8'd2; B = 8'd3; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (complete === 1'b1 && prev !== 1'b1) rises++;
            prev = complete;
        end
        n_checks++;
        if (rises !== 1 || complete !== 1'b1 || busy !== 1'b0 || P !== 16'd6) begin
            n_fail++;
            $display("FAIL hold_start: completions=%0d complete=%b busy=%b P=%h, required 1 1 0 0006", rises, complete, busy, P);
        end
        start = 1'b0;
        tick;
        A = 8'd4; B = 8'd5; start = 1'b1;
        tick;
        n_checks++;
        if (complete !== 1'b0 || busy !== 1'b1 || P !== 16'd6) begin
            n_fail++;
            $display("FAIL hold_restart_accept: complete=%b busy=%b P=%h, required complete=0 busy=1 P=0006", complete, busy, P);
        end
        for (int i = 1; i < lat_of(8'd5); i++) tick;
        tick;
        n_checks++;
        if (complete !== 1'b1 || P !== 16'd20) begin
            n_fail++;
            $display("FAIL hold_restart_done: complete=%b P=%h, required complete=1 P=0014", complete, P);
        end
        start = 1'b0;
        tick;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_p   = 16'd0;
        test_reset;
        test_multiply("basic_13x11", 8'd13, 8'd11, 16'h008F);
        test_multiply("max_255x255", 8'hFF, 8'hFF, 16'hFE01);
        test_multiply("zero_b", 8'hAB, 8'h00, 16'h0000);
        test_multiply("ab_x5", 8'hAB, 8'h05, 16'h0357);
        test_multiply("one_b", 8'h5A, 8'h01, 16'h005A);
        test_multiply("msb_b", 8'h03, 8'h80, 16'h0180);
        test_ignore_restart;
        test_reset_mid;
        test_reset_start;
        test_hold_start;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
